board_engine: RTL and testbench



---
 rtl/game_pkg.sv | 58 +++++
 rtl/board_match_mask.sv | 48 ++++
 rtl/board_engine.sv | 244 ++++++++++++++++++++++++
 tb/tb_board_engine.sv | 280 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/game_pkg.sv
// Shared definitions for the match-3 board engine.
// Provides the colour codes, the FSM state type, swap directions, the LFSR
// taps and seed, and small helpers for popcount, refill colour and the
// reset board pattern.
package game_pkg;

  localparam int unsigned N               = 8;
  localparam int unsigned NCELLS          = N * N;
  localparam int unsigned NCOLORS         = 6;
  localparam int unsigned MAX_CASCADE_DEF = 15;

  localparam logic [2:0] COLOR_RED    = 3'd0;
  localparam logic [2:0] COLOR_GREEN  = 3'd1;
  localparam logic [2:0] COLOR_BLUE   = 3'd2;
  localparam logic [2:0] COLOR_YELLOW = 3'd3;
  localparam logic [2:0] COLOR_PURPLE = 3'd4;
  localparam logic [2:0] COLOR_WHITE  = 3'd5;
  localparam logic [2:0] COLOR_EMPTY  = 3'd7;

  localparam logic DIR_RIGHT = 1'b0;
  localparam logic DIR_DOWN  = 1'b1;

  // x^16 + x^14 + x^13 + x^11 -> state bits 15, 13, 12, 10
  localparam logic [15:0] LFSR_TAPS = 16'hB400;
  localparam logic [15:0] LFSR_SEED = 16'hACE1;

  typedef enum logic [2:0] {
    StIdle,
    StSwap,
    StScan,
    StClear,
    StFall,
    StUnswap
  } state_e;

  function automatic logic [6:0] popcount64(input logic [NCELLS-1:0] v);
    logic [6:0] cnt;
    cnt = '0;
    for (int i = 0; i < NCELLS; i++) begin
      cnt = cnt + 7'(v[i]);
    end
    return cnt;
  endfunction

  // Each column draws its own 4-bit nibble from the LFSR so that columns
  // refilled in the same cycle do not all receive the same colour.
  function automatic logic [2:0] refill_color(input logic [15:0] lfsr, input int unsigned col);
    logic [3:0] raw;
    raw = {lfsr[4'((2 * col + 3) % 16)], lfsr[4'((2 * col + 2) % 16)],
           lfsr[4'((2 * col + 1) % 16)], lfsr[4'((2 * col) % 16)]};
    return 3'(raw % 4'd6);
  endfunction

  function automatic logic [2:0] reset_color(input int unsigned idx);
    return 3'(idx % NCOLORS);
  endfunction

endpackage

// File: rtl/board_match_mask.sv
// Combinational run detector for the 8x8 board.
// Ports:
//   i_board - 64 cells x 3 bits, cell (r,c) at bits [3*(8r+c) +: 3]
//   o_mask  - bit 8r+c set when the cell is part of a horizontal or
//             vertical run of three or more equal non-EMPTY colours
module board_match_mask
  import game_pkg::*;
(
  input  logic [3*NCELLS-1:0] i_board,
  output logic [NCELLS-1:0]   o_mask
);

  logic [2:0] w_cell [NCELLS];

  always_comb begin
    for (int i = 0; i < NCELLS; i++) begin
      w_cell[i] = i_board[3*i +: 3];
    end
  end

  // Any run longer than three is covered by overlapping 3-windows.
  always_comb begin
    o_mask = '0;
    for (int r = 0; r < N; r++) begin
      for (int c = 0; c < N - 2; c++) begin
        if (w_cell[r*N+c] != COLOR_EMPTY &&
            w_cell[r*N+c] == w_cell[r*N+c+1] &&
            w_cell[r*N+c] == w_cell[r*N+c+2]) begin
          o_mask[r*N+c]   = 1'b1;
          o_mask[r*N+c+1] = 1'b1;
          o_mask[r*N+c+2] = 1'b1;
        end
      end
    end
    for (int r = 0; r < N - 2; r++) begin
      for (int c = 0; c < N; c++) begin
        if (w_cell[r*N+c] != COLOR_EMPTY &&
            w_cell[r*N+c] == w_cell[(r+1)*N+c] &&
            w_cell[r*N+c] == w_cell[(r+2)*N+c]) begin
          o_mask[r*N+c]     = 1'b1;
          o_mask[(r+1)*N+c] = 1'b1;
          o_mask[(r+2)*N+c] = 1'b1;
        end
      end
    end
  end

endmodule

// File: rtl/board_engine.sv
// Match-3 game-state engine: owns the 8x8 board, executes swaps, clears
// runs, applies gravity with LFSR refill and cascades until stable.
// Ports:
//   clk, clrn                  - clock, async active-low reset
//   swap_valid/swap_ready      - swap handshake; ready only in idle
//   swap_row/col/dir           - first cell and direction (0 right, 1 down)
//   swap_done/swap_ok          - completion pulse and kept/rejected flag
//   ld_valid/row/col/color     - debug cell write, idle only
//   rd_row/rd_col/rd_color     - registered render read, 7 = EMPTY
//   busy                       - not idle
//   score                      - saturating cleared-cell count
module board_engine
  import game_pkg::*;
#(
  parameter logic [15:0] SEED        = LFSR_SEED,
  parameter int unsigned MAX_CASCADE = MAX_CASCADE_DEF
) (
  input  logic        clk,
  input  logic        clrn,
  input  logic        swap_valid,
  output logic        swap_ready,
  input  logic [2:0]  swap_row,
  input  logic [2:0]  swap_col,
  input  logic        swap_dir,
  output logic        swap_done,
  output logic        swap_ok,
  input  logic        ld_valid,
  input  logic [2:0]  ld_row,
  input  logic [2:0]  ld_col,
  input  logic [2:0]  ld_color,
  input  logic [2:0]  rd_row,
  input  logic [2:0]  rd_col,
  output logic [2:0]  rd_color,
  output logic        busy,
  output logic [15:0] score
);

  state_e      r_state, w_state_d;
  logic [2:0]  r_board [NCELLS];
  logic [2:0]  w_board_d [NCELLS];
  logic [15:0] r_lfsr;
  logic [15:0] r_score, w_score_d;
  logic [3:0]  r_cascade, w_cascade_d;
  logic        r_first, w_first_d;
  logic [5:0]  r_idx_a, w_idx_a_d;
  logic [5:0]  r_idx_b, w_idx_b_d;
  logic        r_swap_done, w_swap_done_d;
  logic        r_swap_ok, w_swap_ok_d;
  logic [2:0]  r_rd_color;

  logic [3*NCELLS-1:0] w_board_flat;
  logic [NCELLS-1:0]   w_mask;
  logic [6:0]          w_popcnt;
  logic [16:0]         w_score_sum;
  logic [2:0]          w_refill [N];
  logic                w_col_empty [N];
  logic [2:0]          w_col_low [N];
  logic [2:0]          w_fall_board [NCELLS];
  logic                w_fall_has_empty;
  logic                w_swap_legal;
  logic [5:0]          w_swap_a;
  logic [5:0]          w_swap_b;

  always_comb begin
    for (int i = 0; i < NCELLS; i++) begin
      w_board_flat[3*i +: 3] = r_board[i];
    end
  end

  board_match_mask u_match (
    .i_board (w_board_flat),
    .o_mask  (w_mask)
  );

  assign w_popcnt    = popcount64(w_mask);
  assign w_score_sum = {1'b0, r_score} + {10'd0, w_popcnt};

  assign w_swap_legal = (swap_dir == DIR_RIGHT) ? (swap_col != 3'd7) : (swap_row != 3'd7);
  assign w_swap_a     = {swap_row, swap_col};
  assign w_swap_b     = (swap_dir == DIR_RIGHT) ? (w_swap_a + 6'd1) : (w_swap_a + 6'd8);

  always_comb begin
    for (int c = 0; c < N; c++) begin
      w_refill[c] = refill_color(r_lfsr, c);
    end
  end

  // Lowest (largest row index) EMPTY cell per column.
  always_comb begin
    for (int c = 0; c < N; c++) begin
      w_col_empty[c] = 1'b0;
      w_col_low[c]   = '0;
      for (int r = 0; r < N; r++) begin
        if (r_board[r*N+c] == COLOR_EMPTY) begin
          w_col_empty[c] = 1'b1;
          w_col_low[c]   = 3'(r);
        end
      end
    end
  end

  // One gravity step: everything above the lowest hole drops one row and
  // row 0 takes the column's refill colour.
  always_comb begin
    w_fall_board = r_board;
    for (int c = 0; c < N; c++) begin
      if (w_col_empty[c]) begin
        for (int r = 1; r < N; r++) begin
          if (3'(r) <= w_col_low[c]) begin
            w_fall_board[r*N+c] = r_board[(r-1)*N+c];
          end
        end
        w_fall_board[c] = w_refill[c];
      end
    end
  end

  always_comb begin
    w_fall_has_empty = 1'b0;
    for (int i = 0; i < NCELLS; i++) begin
      if (w_fall_board[i] == COLOR_EMPTY) begin
        w_fall_has_empty = 1'b1;
      end
    end
  end

  always_comb begin
    w_state_d     = r_state;
    w_board_d     = r_board;
    w_score_d     = r_score;
    w_cascade_d   = r_cascade;
    w_first_d     = r_first;
    w_idx_a_d     = r_idx_a;
    w_idx_b_d     = r_idx_b;
    w_swap_done_d = 1'b0;
    w_swap_ok_d   = 1'b0;
    unique case (r_state)
      StIdle: begin
        if (swap_valid) begin
          if (w_swap_legal) begin
            w_state_d   = StSwap;
            w_idx_a_d   = w_swap_a;
            w_idx_b_d   = w_swap_b;
            w_first_d   = 1'b1;
            w_cascade_d = '0;
          end else begin
            w_swap_done_d = 1'b1;
          end
        end else if (ld_valid) begin
          w_board_d[{ld_row, ld_col}] = ld_color;
        end
      end
      StSwap, StUnswap: begin
        w_board_d[r_idx_a] = r_board[r_idx_b];
        w_board_d[r_idx_b] = r_board[r_idx_a];
        if (r_state == StSwap) begin
          w_state_d = StScan;
        end else begin
          w_state_d     = StIdle;
          w_swap_done_d = 1'b1;
        end
      end
      StScan: begin
        if (|w_mask) begin
          w_state_d = StClear;
        end else if (r_first) begin
          w_state_d = StUnswap;
        end else begin
          w_state_d     = StIdle;
          w_swap_done_d = 1'b1;
          w_swap_ok_d   = 1'b1;
        end
      end
      StClear: begin
        for (int i = 0; i < NCELLS; i++) begin
          if (w_mask[i]) begin
            w_board_d[i] = COLOR_EMPTY;
          end
        end
        w_score_d   = w_score_sum[16] ? 16'hFFFF : w_score_sum[15:0];
        w_cascade_d = r_cascade + 4'd1;
        w_first_d   = 1'b0;
        w_state_d   = StFall;
      end
      StFall: begin
        w_board_d = w_fall_board;
        if (!w_fall_has_empty) begin
          if (32'(r_cascade) == MAX_CASCADE) begin
            w_state_d     = StIdle;
            w_swap_done_d = 1'b1;
            w_swap_ok_d   = 1'b1;
          end else begin
            w_state_d = StScan;
          end
        end
      end
      default: w_state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or negedge clrn) begin
    if (!clrn) begin
      r_state <= StIdle;
    end else begin
      r_state <= w_state_d;
    end
  end

  always_ff @(posedge clk or negedge clrn) begin
    if (!clrn) begin
      for (int i = 0; i < NCELLS; i++) begin
        r_board[i] <= reset_color(i);
      end
      r_lfsr      <= SEED;
      r_score     <= '0;
      r_cascade   <= '0;
      r_first     <= 1'b0;
      r_idx_a     <= '0;
      r_idx_b     <= '0;
      r_swap_done <= 1'b0;
      r_swap_ok   <= 1'b0;
      r_rd_color  <= '0;
    end else begin
      r_board     <= w_board_d;
      r_lfsr      <= {r_lfsr[14:0], ^(r_lfsr & LFSR_TAPS)};
      r_score     <= w_score_d;
      r_cascade   <= w_cascade_d;
      r_first     <= w_first_d;
      r_idx_a     <= w_idx_a_d;
      r_idx_b     <= w_idx_b_d;
      r_swap_done <= w_swap_done_d;
      r_swap_ok   <= w_swap_ok_d;
      r_rd_color  <= r_board[{rd_row, rd_col}];
    end
  end

  assign swap_ready = (r_state == StIdle);
  assign busy       = ~swap_ready;
  assign swap_done  = r_swap_done;
  assign swap_ok    = r_swap_ok;
  assign rd_color   = r_rd_color;
  assign score      = r_score;

endmodule

// File: tb/tb_board_engine.sv
// Self-checking bench for board_engine: reset pattern sweep, a table of
// swap vectors from the reset board, and hand-written sequences for a
// matching swap, reset during FALL and swap/ld arbitration.
module tb_board_engine;

  logic        clk = 1'b0;
  logic        clrn = 1'b1;
  logic        swap_valid = 1'b0;
  logic        swap_ready;
  logic [2:0]  swap_row = '0;
  logic [2:0]  swap_col = '0;
  logic        swap_dir = 1'b0;
  logic        swap_done;
  logic        swap_ok;
  logic        ld_valid = 1'b0;
  logic [2:0]  ld_row = '0;
  logic [2:0]  ld_col = '0;
  logic [2:0]  ld_color = '0;
  logic [2:0]  rd_row = '0;
  logic [2:0]  rd_col = '0;
  logic [2:0]  rd_color;
  logic        busy;
  logic [15:0] score;

  always #10 clk = ~clk;

  board_engine dut (
    .clk        (clk),
    .clrn       (clrn),
    .swap_valid (swap_valid),
    .swap_ready (swap_ready),
    .swap_row   (swap_row),
    .swap_col   (swap_col),
    .swap_dir   (swap_dir),
    .swap_done  (swap_done),
    .swap_ok    (swap_ok),
    .ld_valid   (ld_valid),
    .ld_row     (ld_row),
    .ld_col     (ld_col),
    .ld_color   (ld_color),
    .rd_row     (rd_row),
    .rd_col     (rd_col),
    .rd_color   (rd_color),
    .busy       (busy),
    .score      (score)
  );

  int n_checks = 0;
  int n_fail   = 0;
  logic [2:0] cells [64];

  typedef struct {
    logic [2:0] row;
    logic [2:0] col;
    logic       dir;
    int         lat;
    logic       ok;
    logic       busy;
  } swap_vec_t;

  swap_vec_t vecs [6];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  function automatic logic [2:0] rst_color(input int r, input int c);
    return 3'((8 * r + c) % 6);
  endfunction

  // Called at #1 after a rising edge; returns at #1 after the edge with rd_color valid.
  task automatic read_cell(input int r, input int c, output logic [2:0] val);
    rd_row = 3'(r);
    rd_col = 3'(c);
    @(posedge clk); #1;
    val = rd_color;
  endtask

  task automatic ld_cell(input int r, input int c, input logic [2:0] col);
    ld_valid = 1'b1;
    ld_row   = 3'(r);
    ld_col   = 3'(c);
    ld_color = col;
    @(posedge clk); #1;
    ld_valid = 1'b0;
  endtask

  // lat = rising edges after the accept edge E0 until swap_done is seen.
  task automatic do_swap(input logic [2:0] r, input logic [2:0] c, input logic d,
                         output int lat, output logic ok, output logic saw_busy);
    swap_row   = r;
    swap_col   = c;
    swap_dir   = d;
    swap_valid = 1'b1;
    @(posedge clk); #1;
    swap_valid = 1'b0;
    lat        = 0;
    saw_busy   = busy;
    while (!swap_done && lat < 2000) begin
      @(posedge clk); #1;
      lat++;
      if (busy) saw_busy = 1'b1;
    end
    ok = swap_ok;
    chk("swap_done_seen", 32'(swap_done), 32'd1);
  endtask

  task automatic apply_reset();
    clrn = 1'b0;
    @(posedge clk); #1;
    @(negedge clk);
    clrn = 1'b1;
    @(posedge clk); #1;
  endtask

  task automatic sweep_reset_pattern(input string name);
    logic [2:0] v;
    for (int r = 0; r < 8; r++) begin
      for (int c = 0; c < 8; c++) begin
        read_cell(r, c, v);
        chk(name, 32'(v), 32'(rst_color(r, c)));
      end
    end
  endtask

  function automatic int count_runs();
    int n;
    n = 0;
    for (int r = 0; r < 8; r++) begin
      for (int c = 0; c < 6; c++) begin
        if (cells[r*8+c] != 3'd7 && cells[r*8+c] == cells[r*8+c+1] &&
            cells[r*8+c] == cells[r*8+c+2]) n++;
      end
    end
    for (int r = 0; r < 6; r++) begin
      for (int c = 0; c < 8; c++) begin
        if (cells[r*8+c] != 3'd7 && cells[r*8+c] == cells[(r+1)*8+c] &&
            cells[r*8+c] == cells[(r+2)*8+c]) n++;
      end
    end
    return n;
  endfunction

  initial begin
    int         lat;
    logic       ok;
    logic       sb;
    logic [2:0] v;

    // None of these swaps on the reset board produces a run.
    vecs[0] = '{row: 3'd0, col: 3'd0, dir: 1'b0, lat: 3, ok: 1'b0, busy: 1'b1};
    vecs[1] = '{row: 3'd3, col: 3'd7, dir: 1'b0, lat: 0, ok: 1'b0, busy: 1'b0};
    vecs[2] = '{row: 3'd4, col: 3'd4, dir: 1'b1, lat: 3, ok: 1'b0, busy: 1'b1};
    vecs[3] = '{row: 3'd7, col: 3'd2, dir: 1'b1, lat: 0, ok: 1'b0, busy: 1'b0};
    vecs[4] = '{row: 3'd6, col: 3'd6, dir: 1'b0, lat: 3, ok: 1'b0, busy: 1'b1};
    vecs[5] = '{row: 3'd7, col: 3'd7, dir: 1'b1, lat: 0, ok: 1'b0, busy: 1'b0};

    #2 clrn = 1'b0;
    #20;
    chk("rst_swap_ready", 32'(swap_ready), 32'd1);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_score", 32'(score), 32'd0);
    chk("rst_rd_color", 32'(rd_color), 32'd0);
    chk("rst_swap_done", 32'(swap_done), 32'd0);
    chk("rst_swap_ok", 32'(swap_ok), 32'd0);
    @(negedge clk);
    clrn = 1'b1;
    @(posedge clk); #1;

    sweep_reset_pattern("rst_cell");

    // Swap vector table from the reset board.
    for (int i = 0; i < 6; i++) begin
      do_swap(vecs[i].row, vecs[i].col, vecs[i].dir, lat, ok, sb);
      chk("vec_latency", 32'(lat), 32'(vecs[i].lat));
      chk("vec_ok", 32'(ok), 32'(vecs[i].ok));
      chk("vec_busy_seen", 32'(sb), 32'(vecs[i].busy));
      @(posedge clk); #1;
      chk("vec_done_pulse", 32'(swap_done), 32'd0);
      read_cell(int'(vecs[i].row), int'(vecs[i].col), v);
      chk("vec_cell_a", 32'(v), 32'(rst_color(int'(vecs[i].row), int'(vecs[i].col))));
      if (vecs[i].busy) begin
        if (vecs[i].dir) begin
          read_cell(int'(vecs[i].row) + 1, int'(vecs[i].col), v);
          chk("vec_cell_b", 32'(v), 32'(rst_color(int'(vecs[i].row) + 1, int'(vecs[i].col))));
        end else begin
          read_cell(int'(vecs[i].row), int'(vecs[i].col) + 1, v);
          chk("vec_cell_b", 32'(v), 32'(rst_color(int'(vecs[i].row), int'(vecs[i].col) + 1)));
        end
      end
      chk("vec_score", 32'(score), 32'd0);
    end

    // Matching swap: row 3 becomes 1 1 1 2 ...
    ld_cell(3, 0, 3'd1);
    ld_cell(3, 1, 3'd1);
    ld_cell(3, 3, 3'd1);
    read_cell(3, 0, v);
    chk("ld_cell_30", 32'(v), 32'd1);
    read_cell(3, 3, v);
    chk("ld_cell_33", 32'(v), 32'd1);
    chk("ld_score", 32'(score), 32'd0);
    do_swap(3'd3, 3'd2, 1'b0, lat, ok, sb);
    chk("match_ok", 32'(ok), 32'd1);
    chk("match_busy_seen", 32'(sb), 32'd1);
    chk("match_score_ge3", 32'(score >= 16'd3), 32'd1);
    for (int r = 0; r < 8; r++) begin
      for (int c = 0; c < 8; c++) begin
        read_cell(r, c, v);
        cells[r*8+c] = v;
        chk("match_no_empty", 32'(v != 3'd7), 32'd1);
      end
    end
    // Reaching the cascade cap needs at least 46 edges; below that no run may remain.
    if (lat < 46) chk("match_no_run", 32'(count_runs()), 32'd0);

    // Reset during FALL.
    apply_reset();
    ld_cell(3, 0, 3'd1);
    ld_cell(3, 1, 3'd1);
    ld_cell(3, 3, 3'd1);
    swap_row   = 3'd3;
    swap_col   = 3'd2;
    swap_dir   = 1'b0;
    swap_valid = 1'b1;
    @(posedge clk); #1;
    swap_valid = 1'b0;
    repeat (3) begin
      @(posedge clk); #1;
    end
    chk("fall_busy", 32'(busy), 32'd1);
    chk("fall_score", 32'(score), 32'd3);
    clrn = 1'b0;
    #1;
    chk("abort_ready", 32'(swap_ready), 32'd1);
    chk("abort_busy", 32'(busy), 32'd0);
    chk("abort_score", 32'(score), 32'd0);
    chk("abort_rd_color", 32'(rd_color), 32'd0);
    chk("abort_done", 32'(swap_done), 32'd0);
    @(negedge clk);
    clrn = 1'b1;
    @(posedge clk); #1;
    sweep_reset_pattern("abort_cell");

    // Swap and ld in the same idle cycle; ld while busy.
    swap_row   = 3'd0;
    swap_col   = 3'd0;
    swap_dir   = 1'b0;
    swap_valid = 1'b1;
    ld_valid   = 1'b1;
    ld_row     = 3'd5;
    ld_col     = 3'd5;
    ld_color   = 3'd0;
    @(posedge clk); #1;
    swap_valid = 1'b0;
    chk("arb_accepted", 32'(busy), 32'd1);
    ld_col = 3'd6;
    lat    = 0;
    while (!swap_done && lat < 100) begin
      @(posedge clk); #1;
      lat++;
    end
    ld_valid = 1'b0;
    chk("arb_latency", 32'(lat), 32'd3);
    read_cell(5, 5, v);
    chk("arb_ld_same_cycle", 32'(v), 32'd3);
    read_cell(5, 6, v);
    chk("arb_ld_busy", 32'(v), 32'd4);
    read_cell(0, 0, v);
    chk("arb_cell_00", 32'(v), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
